fifo_feed_sched: RTL and testbench

//  Read-side scheduler for a bank of ROWS row FIFOs feeding the west edge of the systolic array.

---
 rtl/fifo_feed_sched_pkg.sv | 20 ++
 rtl/fifo_feed_window.sv | 30 +++
 rtl/fifo_feed_sched.sv | 151 +++++++++++++++
 tb/tb_fifo_feed_sched.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_feed_sched_pkg.sv
// fifo_feed_sched_pkg
//   Shared definitions for the row-FIFO read scheduler: FSM state encoding,
//   stall counter width and the wavefront counter width helper.
package fifo_feed_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned STALL_CNT_W = 16;

    // Wavefront counter width: must hold len_q + ROWS - 1 without wrapping.
    function automatic int unsigned tw(input int unsigned rows, input int unsigned len_width);
        return len_width + int'($clog2(rows)) + 1;
    endfunction

endpackage

// File: rtl/fifo_feed_window.sv
// fifo_feed_window
//   Per-row issue window: a row needs a read while the wavefront counter lies
//   inside [row, row + len_q). All comparisons are done in the full counter width.
// Ports
//   t_i      wavefront counter
//   len_q_i  latched job length
//   row_i    this row's index (start offset of its window)
//   run_i    scheduler is in RUN
//   need_o   this row wants a read this cycle
module fifo_feed_window #(
    parameter int unsigned TW        = 11,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic [TW-1:0]        t_i,
    input  logic [LEN_WIDTH-1:0] len_q_i,
    input  logic [TW-1:0]        row_i,
    input  logic                 run_i,
    output logic                 need_o
);

    logic [TW-1:0] len_ext;
    logic [TW-1:0] win_end;

    always_comb begin
        len_ext = TW'(len_q_i);
        win_end = row_i + len_ext;
        need_o  = run_i && (t_i >= row_i) && (t_i < win_end);
    end

endmodule

// File: rtl/fifo_feed_sched.sv
// fifo_feed_sched
//   Read-side scheduler for ROWS row FIFOs feeding the west edge of a systolic
//   array. Row i starts reading i cycles after row 0 and receives exactly len
//   reads per job. If any FIFO needed in a cycle is empty, the whole wavefront
//   stalls so the diagonal skew is preserved.
// Optional feature (macro FEED_SCHED_STALL_CNT_EN): adds the stall_cycles port,
//   a saturating count of stalled RUN cycles, cleared on an accepted start.
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   start        job request, sampled only in IDLE
//   len          reads per row, latched with start
//   fifo_empty   empty flags of the row FIFOs, bit i = row i
//   r_en         read enables (combinational from state, t and fifo_empty)
//   valid_out    r_en delayed one cycle, qualifies registered FIFO data
//   busy         high in RUN and DRAIN
//   done         one-cycle pulse in DONE
//   stall_cycles stalled RUN cycle count (FEED_SCHED_STALL_CNT_EN only)
module fifo_feed_sched
    import fifo_feed_sched_pkg::*;
#(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   len,
    input  logic [ROWS-1:0]        fifo_empty,
    output logic [ROWS-1:0]        r_en,
    output logic [ROWS-1:0]        valid_out,
    output logic                   busy,
    output logic                   done
`ifdef FEED_SCHED_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

    localparam int unsigned TW = tw(ROWS, LEN_WIDTH);

    state_e               state_q;
    logic [TW-1:0]        t_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [ROWS-1:0]      valid_q;
    logic                 busy_q;
    logic                 done_q;

    logic [ROWS-1:0]      need;
    logic                 run;
    logic                 stall;
    logic [TW-1:0]        last_t;
    logic                 last_issue;

    assign run = (state_q == RUN);

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        fifo_feed_window #(
            .TW        (TW),
            .LEN_WIDTH (LEN_WIDTH)
        ) u_window (
            .t_i     (t_q),
            .len_q_i (len_q),
            .row_i   (TW'(i)),
            .run_i   (run),
            .need_o  (need[i])
        );
    end

    always_comb begin
        stall = |(need & fifo_empty);
        r_en  = stall ? '0 : need;
        // Last wavefront step: row ROWS-1 issues its final read at len_q + ROWS - 2.
        // len_q >= 1 in RUN, so this never goes negative.
        last_t     = TW'(len_q) + TW'(ROWS) - TW'(2);
        last_issue = run && !stall && (t_q == last_t);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            len_q   <= '0;
            valid_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // valid_out follows r_en every cycle, regardless of state changes.
            valid_q <= r_en;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        t_q   <= '0;
                        if (len != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!stall) begin
                        t_q <= t_q + TW'(1);
                    end
                    if (last_issue) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign valid_out = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef FEED_SCHED_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            stall_cnt_q <= '0;
        end else if (run && stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_feed_sched.sv
module tb_fifo_feed_sched;

    localparam int ROWS = 4;
    localparam int LW   = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic [3:0]    fifo_empty;
    logic [3:0]    r_en;
    logic [3:0]    valid_out;
    logic          busy;
    logic          done;
`ifdef FEED_SCHED_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    fifo_feed_sched #(
        .ROWS      (ROWS),
        .LEN_WIDTH (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .fifo_empty   (fifo_empty),
        .r_en         (r_en),
        .valid_out    (valid_out),
        .busy         (busy),
        .done         (done)
`ifdef FEED_SCHED_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic [7:0] len;
        logic [3:0] fe;
        logic [3:0] er;
        logic [3:0] ev;
        logic       eb;
        logic       ed;
        int         reads;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   rd_cnt[ROWS];

    task automatic add(input logic rs, input logic st, input logic [7:0] ln, input logic [3:0] fe,
                       input logic [3:0] er, input logic [3:0] ev, input logic eb,
                       input logic ed, input int rd);
        vec_t v;
        v.rst = rs; v.start = st; v.len = ln; v.fe = fe;
        v.er = er; v.ev = ev; v.eb = eb; v.ed = ed; v.reads = rd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; fifo_empty = '0;
        foreach (rd_cnt[i]) rd_cnt[i] = 0;

        // Reset state.
        add(1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        // len=3 job.
        add(0, 1, 3, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        add(0, 0, 0, 4'h0, 4'h1, 4'h0, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h3, 4'h1, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h7, 4'h3, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'hE, 4'h7, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'hC, 4'hE, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h8, 4'hC, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h8, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 1, 3);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        // len=3 job with start/len=9 re-asserted in RUN, DRAIN and DONE.
        add(0, 1, 3, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        add(0, 0, 0, 4'h0, 4'h1, 4'h0, 1, 0, -1);
        add(0, 1, 9, 4'h0, 4'h3, 4'h1, 1, 0, -1);
        add(0, 1, 9, 4'h0, 4'h7, 4'h3, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'hE, 4'h7, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'hC, 4'hE, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h8, 4'hC, 1, 0, -1);
        add(0, 1, 9, 4'h0, 4'h0, 4'h8, 1, 0, -1);
        add(0, 1, 9, 4'h0, 4'h0, 4'h0, 0, 1, 3);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        // len=0 job: straight to DONE; len without start ignored.
        add(0, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 1, 0);
        add(0, 0, 5, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        add(0, 0, 5, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        // len=5 job reset at t=3, then len=2 job.
        add(0, 1, 5, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        add(0, 0, 0, 4'h0, 4'h1, 4'h0, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h3, 4'h1, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h7, 4'h3, 1, 0, -1);
        add(1, 0, 0, 4'h0, 4'hF, 4'h7, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        add(0, 1, 2, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        add(0, 0, 0, 4'h0, 4'h1, 4'h0, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h3, 4'h1, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h6, 4'h3, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'hC, 4'h6, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h8, 4'hC, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h8, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 1, 2);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        // len=3 job, row 2 empty for 2 cycles at t=2.
        add(0, 1, 3, 4'h0, 4'h0, 4'h0, 0, 0, -1);
        add(0, 0, 0, 4'h0, 4'h1, 4'h0, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h3, 4'h1, 1, 0, -1);
        add(0, 0, 0, 4'h4, 4'h0, 4'h3, 1, 0, -1);
        add(0, 0, 0, 4'h4, 4'h0, 4'h0, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h7, 4'h0, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'hE, 4'h7, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'hC, 4'hE, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h8, 4'hC, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h8, 1, 0, -1);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 1, 3);
        add(0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, -1);

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            rst = vecs[n].rst; start = vecs[n].start;
            len = vecs[n].len; fifo_empty = vecs[n].fe;
            #1;
            check($sformatf("vec%0d {r_en,valid_out,busy,done}", n),
                  32'({r_en, valid_out, busy, done}),
                  32'({vecs[n].er, vecs[n].ev, vecs[n].eb, vecs[n].ed}));
            for (int i = 0; i < ROWS; i++) rd_cnt[i] += int'(r_en[i]);
            if (vecs[n].reads >= 0) begin
                for (int i = 0; i < ROWS; i++) begin
                    check($sformatf("vec%0d reads row%0d", n, i), 32'(rd_cnt[i]),
                          32'(vecs[n].reads));
                    rd_cnt[i] = 0;
                end
            end
            if (vecs[n].rst) begin
                for (int i = 0; i < ROWS; i++) rd_cnt[i] = 0;
            end
        end

`ifdef FEED_SCHED_STALL_CNT_EN
        check("stall_cycles", 32'(stall_cycles), 32'd2);
`endif

        // Random stimulus with a 2-cycle reset in the middle.
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rst = 1'b0;
            start = 1'($urandom_range(0, 1));
            len = 8'($urandom_range(0, 6));
            fifo_empty = 4'($urandom);
            #1;
            check("no read of empty fifo", 32'(r_en & fifo_empty), 32'd0);
            if (c == 20) begin
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    rst = 1'b1;
                    start = 1'($urandom_range(0, 1));
                    fifo_empty = 4'($urandom);
                    @(posedge clk);
                    #1;
                    check($sformatf("mid reset %0d", k), 32'({r_en, valid_out, busy, done}),
                          32'd0);
                end
                @(negedge clk);
                rst = 1'b0; start = 1'b0; fifo_empty = '0;
                @(posedge clk);
                #1;
                check("idle after reset", 32'({r_en, valid_out, busy, done}), 32'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
